req_ack_fifo: RTL and testbench

Elastic buffer for the req/ack dataflow fabric, placed between an `arf` output port (`dout_req_N`/`dout_ack_N`/`dout_N`) and its downstream consumer.
- Upstream, it behaves as a consumer: it pulls words while it has room.
- Downstream, it behaves as a producer: it serves requests from stored words.
- It decouples consumer stalls (`fail_rate`) from the dataflow graph, so measured throughput reflects graph structure rather than sink backpressure.

---
 rtl/dataflow_pkg.sv | 9 +
 rtl/req_ack_fifo_if.sv | 40 ++++
 rtl/req_ack_fifo_mem.sv | 23 ++
 rtl/req_ack_fifo.sv | 102 ++++++++++
 tb/tb_req_ack_fifo.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/dataflow_pkg.sv
// dataflow_pkg: widths and helpers shared by the req/ack dataflow blocks.
package dataflow_pkg;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int COUNT_W = 32;

    function automatic int ptr_w(input int d);
        return $clog2(d);
    endfunction
endpackage

// File: rtl/req_ack_fifo_if.sv
// req_ack_fifo_if: upstream/downstream handshake bundle of req_ack_fifo.
// Stats signals exist only when REQ_ACK_FIFO_STATS_EN is defined.
interface req_ack_fifo_if #(
    parameter int data_width = dataflow_pkg::DEFAULT_DATA_WIDTH,
    parameter int depth = 4
);
    localparam int LW = dataflow_pkg::ptr_w(depth) + 1;

    logic                  req_l;
    logic                  ack_l;
    logic [data_width-1:0] din;
    logic                  req_r;
    logic                  ack_r;
    logic [data_width-1:0] dout;
    logic [LW-1:0]         level;
    logic                  overflow;
`ifdef REQ_ACK_FIFO_STATS_EN
    logic [dataflow_pkg::COUNT_W-1:0] count_in;
    logic [dataflow_pkg::COUNT_W-1:0] count_out;
    logic [LW-1:0]                    max_level;

    modport slave (
        input  ack_l, din, req_r,
        output req_l, ack_r, dout, level, overflow, count_in, count_out, max_level
    );
    modport master (
        output ack_l, din, req_r,
        input  req_l, ack_r, dout, level, overflow, count_in, count_out, max_level
    );
`else
    modport slave (
        input  ack_l, din, req_r,
        output req_l, ack_r, dout, level, overflow
    );
    modport master (
        output ack_l, din, req_r,
        input  req_l, ack_r, dout, level, overflow
    );
`endif
endinterface

// File: rtl/req_ack_fifo_mem.sv
// req_ack_fifo_mem: depth x data_width register array, one write port, async read.
module req_ack_fifo_mem
    import dataflow_pkg::*;
#(
    parameter int data_width = DEFAULT_DATA_WIDTH,
    parameter int depth = 4,
    localparam int AW = ptr_w(depth)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [data_width-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [data_width-1:0] rdata
);
    logic [data_width-1:0] mem_q [depth];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/req_ack_fifo.sv
// req_ack_fifo: elastic req/ack buffer between an arf output port and its consumer.
// Optional occupancy/throughput counters under REQ_ACK_FIFO_STATS_EN.
module req_ack_fifo
    import dataflow_pkg::*;
#(
    parameter int data_width = DEFAULT_DATA_WIDTH,
    parameter int depth = 4,
    parameter logic [data_width-1:0] initial_value = '0
) (
    input logic           clk,
    input logic           rst,
    req_ack_fifo_if.slave bus
);
    localparam int PW = ptr_w(depth);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL = LW'(depth);
    localparam logic [LW-1:0] HIGH_MARK = LW'(depth - 2);

    logic [PW-1:0]         wp_q, wp_d, rp_q, rp_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  req_l_q, req_l_d;
    logic                  ack_r_q, ack_r_d;
    logic                  overflow_q, overflow_d;
    logic [data_width-1:0] dout_q, dout_d;
    logic [data_width-1:0] rdata;
    logic                  push, pop;

    req_ack_fifo_mem #(.data_width(data_width), .depth(depth)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wp_q),
        .wdata (bus.din),
        .raddr (rp_q),
        .rdata (rdata)
    );

    // A pop on the same edge frees a slot, so a full buffer still accepts the push.
    always_comb begin
        pop        = bus.req_r && !ack_r_q && (level_q != '0);
        push       = bus.ack_l && ((level_q != FULL) || pop);
        wp_d       = push ? wp_q + PW'(1) : wp_q;
        rp_d       = pop ? rp_q + PW'(1) : rp_q;
        level_d    = level_q + LW'(push) - LW'(pop);
        req_l_d    = level_d <= HIGH_MARK;
        ack_r_d    = pop;
        dout_d     = pop ? rdata : dout_q;
        overflow_d = overflow_q || (bus.ack_l && !push);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q       <= '0;
            rp_q       <= '0;
            level_q    <= '0;
            req_l_q    <= 1'b0;
            ack_r_q    <= 1'b0;
            dout_q     <= initial_value;
            overflow_q <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            level_q    <= level_d;
            req_l_q    <= req_l_d;
            ack_r_q    <= ack_r_d;
            dout_q     <= dout_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.req_l    = req_l_q;
    assign bus.ack_r    = ack_r_q;
    assign bus.dout     = dout_q;
    assign bus.level    = level_q;
    assign bus.overflow = overflow_q;

`ifdef REQ_ACK_FIFO_STATS_EN
    logic [COUNT_W-1:0] count_in_q, count_in_d, count_out_q, count_out_d;
    logic [LW-1:0]      max_level_q, max_level_d;

    always_comb begin
        count_in_d  = count_in_q + COUNT_W'(push);
        count_out_d = count_out_q + COUNT_W'(pop);
        max_level_d = (level_d > max_level_q) ? level_d : max_level_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_in_q  <= '0;
            count_out_q <= '0;
            max_level_q <= '0;
        end else begin
            count_in_q  <= count_in_d;
            count_out_q <= count_out_d;
            max_level_q <= max_level_d;
        end
    end

    assign bus.count_in  = count_in_q;
    assign bus.count_out = count_out_q;
    assign bus.max_level = max_level_q;
`endif
endmodule

// File: tb/tb_req_ack_fifo.sv
// tb_req_ack_fifo: directed stimulus with a scoreboard queue checked by a downstream monitor.
module tb_req_ack_fifo;
    localparam int DW = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    req_ack_fifo_if #(.data_width(DW), .depth(DEPTH)) bus ();

    req_ack_fifo #(.data_width(DW), .depth(DEPTH), .initial_value('0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_rx = 0;
    logic [DW-1:0] exp_q[$];
    logic prev_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (bus.ack_r === 1'b1) begin
            chk("ack_gap", 32'(prev_ack), 0);
            n_rx++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ack: got dout %0h want no ack at %0t", bus.dout, $time);
            end else begin
                chk("dout", bus.dout, exp_q.pop_front());
            end
        end
        prev_ack = bus.ack_r;
    end

    task automatic push_req(input logic [31:0] w);
        int t = 0;
        while (!bus.req_l && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.req_l) begin
            n_cmp++;
            n_bad++;
            $display("FAIL req_l_timeout: got 0 want 1 at %0t", $time);
        end else begin
            bus.ack_l = 1'b1;
            bus.din = w;
            exp_q.push_back(w);
            @(negedge clk);
            bus.ack_l = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic push_force(input logic [31:0] w, input bit keep);
        bus.ack_l = 1'b1;
        bus.din = w;
        if (keep) exp_q.push_back(w);
        @(negedge clk);
        bus.ack_l = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int t = 0;
        bus.req_r = 1'b1;
        while ((bus.level != 0 || exp_q.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_pending"}, 32'(exp_q.size()), 0);
        chk({name, "_level"}, 32'(bus.level), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int pushed;
        bus.ack_l = 1'b0;
        bus.din = '0;
        bus.req_r = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_l", 32'(bus.req_l), 0);
        chk("rst_ack_r", 32'(bus.ack_r), 0);
        chk("rst_dout", bus.dout, 0);
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_overflow", 32'(bus.overflow), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("req_l_rise", 32'(bus.req_l), 1);
        chk("idle_ack_r", 32'(bus.ack_r), 0);
        chk("idle_dout", bus.dout, 0);
        @(negedge clk);

        bus.req_r = 1'b1;
        for (int i = 0; i < 5000; i++) push_req(i);
        drain("stream");
        chk("stream_rx", 32'(n_rx), 5000);
        chk("stream_overflow", 32'(bus.overflow), 0);
`ifdef REQ_ACK_FIFO_STATS_EN
        chk("count_in", bus.count_in, 5000);
        chk("count_out", bus.count_out, 5000);
        chk("max_level", 32'(bus.max_level), 1);
`endif

        bus.req_r = 1'b0;
        pushed = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.req_l) begin
                push_req(100 + i);
                pushed++;
            end else begin
                @(negedge clk);
            end
        end
        chk("bp_pushed", 32'(pushed), 3);
        chk("bp_level", 32'(bus.level), 3);
        chk("bp_req_l", 32'(bus.req_l), 0);
        chk("bp_overflow", 32'(bus.overflow), 0);
        drain("bp");
        chk("bp_req_l_back", 32'(bus.req_l), 1);

        bus.req_r = 1'b0;
        for (int i = 0; i < 4; i++) push_force(200 + i, 1'b1);
        chk("full_level", 32'(bus.level), 4);
        chk("full_overflow", 32'(bus.overflow), 0);
        chk("full_req_l", 32'(bus.req_l), 0);
        bus.ack_l = 1'b1;
        bus.din = 204;
        bus.req_r = 1'b1;
        exp_q.push_back(204);
        @(negedge clk);
        bus.ack_l = 1'b0;
        bus.req_r = 1'b0;
        chk("pushpop_level", 32'(bus.level), 4);
        chk("pushpop_overflow", 32'(bus.overflow), 0);
        @(negedge clk);
        drain("pushpop");

        bus.req_r = 1'b0;
        for (int i = 1; i <= 6; i++) push_force(i, i <= 4);
        chk("ovf_level", 32'(bus.level), 4);
        chk("ovf_flag", 32'(bus.overflow), 1);
        drain("ovf");
        chk("ovf_sticky", 32'(bus.overflow), 1);

        bus.req_r = 1'b0;
        for (int i = 0; i < 3; i++) push_req(300 + i);
        chk("mid_level3", 32'(bus.level), 3);
        bus.req_r = 1'b1;
        @(posedge clk);
        #3;
        chk("mid_ack_r", 32'(bus.ack_r), 1);
        chk("mid_level2", 32'(bus.level), 2);
        rst = 1'b0;
        #1;
        chk("async_ack_r", 32'(bus.ack_r), 0);
        chk("async_level", 32'(bus.level), 0);
        chk("async_req_l", 32'(bus.req_l), 0);
        chk("async_dout", bus.dout, 0);
        chk("async_overflow", 32'(bus.overflow), 0);
        @(negedge clk);
        bus.req_r = 1'b0;
        bus.ack_l = 1'b1;
        bus.din = 999;
        exp_q.delete();
        @(negedge clk);
        bus.ack_l = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ack_ignored", 32'(bus.level), 0);
        chk("post_rst_req_l", 32'(bus.req_l), 1);
        bus.req_r = 1'b1;
        push_req(400);
        push_req(401);
        drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
